multicycle_controller: RTL and testbench

- Control FSM for the multicycle MIPS datapath: one shared memory, one ALU, a single clock.
- Sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, beq, addi and j.
- Drives datapath selects and enables, and raises aluop for the existing ALU decoder.
- Adds a memory request/ready handshake so that slow memory stalls the sequence.

---
 rtl/multicycle_controller.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath with a mem_req/mem_ready handshake.
// Slow memory stalls FETCH, MEMRD and MEMWR; a long wait raises a single mem_timeout pulse.
module multicycle_controller #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pcen,
    output logic       irwrite,
    output logic       iord,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic [3:0] state_o,
    output logic       mem_timeout
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] RTYPEEX = 4'd6;
    localparam logic [3:0] RTYPEWB = 4'd7;
    localparam logic [3:0] BEQEX   = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] ADDIWB  = 4'd10;
    localparam logic [3:0] JEX     = 4'd11;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam int            CW        = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX  = CW'(MEM_WAIT_MAX);
    localparam logic [CW-1:0] WAIT_LAST = WAIT_MAX - 1'b1;
    localparam logic          TMO_EN    = (MEM_WAIT_MAX > 0);

    logic [3:0]    state_reg, state_next;
    logic [CW-1:0] wait_cnt_reg;
    logic          timeout_reg;
    logic          mem_wait;

    assign mem_wait = ((state_reg == FETCH) || (state_reg == MEMRD) || (state_reg == MEMWR))
                      && !mem_ready;

    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:   state_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = RTYPEEX;
                    OP_BEQ:       state_next = BEQEX;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JEX;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR:  state_next = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_next = mem_ready ? MEMWB : MEMRD;
            MEMWR:   state_next = mem_ready ? FETCH : MEMWR;
            RTYPEEX: state_next = RTYPEWB;
            ADDIEX:  state_next = ADDIWB;
            default: state_next = FETCH;
        endcase
    end

    // The wait counter saturates at WAIT_MAX, so the pulse can fire only once per access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= FETCH;
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (mem_wait) begin
                if (wait_cnt_reg != WAIT_MAX)
                    wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end else begin
                wait_cnt_reg <= '0;
            end
            timeout_reg <= TMO_EN && mem_wait && (wait_cnt_reg == WAIT_LAST);
        end
    end

    logic       req_d, pcwrite_d, branch_d, irwrite_d, iord_d, memwrite_d;
    logic       regwrite_d, regdst_d, memtoreg_d, alusrca_d;
    logic [1:0] alusrcb_d, pcsrc_d, aluop_d;

    always_comb begin
        req_d      = 1'b0;
        pcwrite_d  = 1'b0;
        branch_d   = 1'b0;
        irwrite_d  = 1'b0;
        iord_d     = 1'b0;
        memwrite_d = 1'b0;
        regwrite_d = 1'b0;
        regdst_d   = 1'b0;
        memtoreg_d = 1'b0;
        alusrca_d  = 1'b0;
        alusrcb_d  = 2'b00;
        pcsrc_d    = 2'b00;
        aluop_d    = 2'b00;
        case (state_reg)
            FETCH: begin
                req_d     = 1'b1;
                alusrcb_d = 2'b01;
                irwrite_d = mem_ready;
                pcwrite_d = mem_ready;
            end
            DECODE:  alusrcb_d = 2'b11;
            MEMADR: begin
                alusrca_d = 1'b1;
                alusrcb_d = 2'b10;
            end
            MEMRD: begin
                req_d  = 1'b1;
                iord_d = 1'b1;
            end
            MEMWB: begin
                memtoreg_d = 1'b1;
                regwrite_d = 1'b1;
            end
            MEMWR: begin
                req_d      = 1'b1;
                iord_d     = 1'b1;
                memwrite_d = mem_ready;
            end
            RTYPEEX: begin
                alusrca_d = 1'b1;
                aluop_d   = 2'b10;
            end
            RTYPEWB: begin
                regdst_d   = 1'b1;
                regwrite_d = 1'b1;
            end
            BEQEX: begin
                alusrca_d = 1'b1;
                aluop_d   = 2'b01;
                pcsrc_d   = 2'b01;
                branch_d  = 1'b1;
            end
            ADDIEX: begin
                alusrca_d = 1'b1;
                alusrcb_d = 2'b10;
            end
            ADDIWB:  regwrite_d = 1'b1;
            JEX: begin
                pcsrc_d   = 2'b10;
                pcwrite_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Gating with reset forces every output low as soon as reset drops, before any clock edge.
    assign mem_req     = reset & req_d;
    assign pcen        = reset & (pcwrite_d | (branch_d & zero));
    assign irwrite     = reset & irwrite_d;
    assign iord        = reset & iord_d;
    assign memwrite    = reset & memwrite_d;
    assign regwrite    = reset & regwrite_d;
    assign regdst      = reset & regdst_d;
    assign memtoreg    = reset & memtoreg_d;
    assign alusrca     = reset & alusrca_d;
    assign alusrcb     = reset ? alusrcb_d : 2'b00;
    assign pcsrc       = reset ? pcsrc_d : 2'b00;
    assign aluop       = reset ? aluop_d : 2'b00;
    assign state_o     = state_reg;
    assign mem_timeout = reset & timeout_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus randomized
// instruction streams checked against an instruction-level path model.
module tb_multicycle_controller;

    localparam int MAXW = 15;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state_o;
    logic       mem_timeout;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .pcen(pcen), .irwrite(irwrite), .iord(iord),
        .memwrite(memwrite), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
        .state_o(state_o), .mem_timeout(mem_timeout)
    );

    // Vector layout: [19:16] state, [15] mem_req, [14] pcen, [13] irwrite, [12] iord,
    // [11] memwrite, [10] regwrite, [9] regdst, [8] memtoreg, [7] alusrca,
    // [6:5] alusrcb, [4:3] pcsrc, [2:1] aluop, [0] mem_timeout
    function automatic logic [19:0] dut_vec();
        return {state_o, mem_req, pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg,
                alusrca, alusrcb, pcsrc, aluop, mem_timeout};
    endfunction

    // Reference model: the remaining states of the current instruction are planned
    // as a queue when its fetch completes; memory states hold while mem_ready is low.
    int m_state;
    int m_path[$];
    int m_wait;
    bit m_tmo;

    function automatic logic [15:0] spec_outs(int st, logic mr, logic z, bit tmo);
        logic req = 0, pc = 0, ir = 0, io = 0, mw = 0, rw = 0, rd = 0, m2r = 0, sa = 0;
        logic [1:0] sb = 0, ps = 0, ao = 0;
        case (st)
            0:  begin req = 1; sb = 2'b01; ir = mr; pc = mr; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin req = 1; io = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin req = 1; io = 1; mw = mr; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pc = z; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pc = 1; end
            default: ;
        endcase
        return {req, pc, ir, io, mw, rw, rd, m2r, sa, sb, ps, ao, tmo};
    endfunction

    task automatic plan(input logic [5:0] o);
        m_path.delete();
        case (o)
            OP_LW:    m_path = '{1, 2, 3, 4};
            OP_SW:    m_path = '{1, 2, 5};
            OP_RTYPE: m_path = '{1, 6, 7};
            OP_BEQ:   m_path = '{1, 8};
            OP_ADDI:  m_path = '{1, 9, 10};
            OP_J:     m_path = '{1, 11};
            default:  m_path = '{1};
        endcase
    endtask

    task automatic model_reset();
        m_state = 0;
        m_path.delete();
        m_wait = 0;
        m_tmo = 0;
    endtask

    task automatic model_edge(input logic mr);
        bit memst;
        memst = (m_state == 0) || (m_state == 3) || (m_state == 5);
        if (memst && !mr) begin
            if (m_wait < MAXW) begin
                m_wait++;
                m_tmo = (m_wait == MAXW);
            end else begin
                m_tmo = 0;
            end
        end else begin
            m_wait = 0;
            m_tmo = 0;
            if (m_state == 0) plan(op);
            m_state = (m_path.size() > 0) ? m_path.pop_front() : 0;
        end
    endtask

    // One clock: apply inputs just after a rising edge, sample at the falling edge,
    // then advance the model at the next rising edge.
    task automatic tick(input logic mr, input logic z, input logic [5:0] o,
                        output logic [19:0] got, output logic [19:0] want);
        mem_ready = mr;
        zero = z;
        op = o;
        @(negedge clk);
        got = dut_vec();
        want = {4'(m_state), spec_outs(m_state, mr, z, m_tmo)};
        @(posedge clk);
        model_edge(mr);
        #1;
    endtask

    task automatic test_reset();
        logic [19:0] got;
        reset = 1'b0;
        mem_ready = 1'b1;
        op = OP_LW;
        model_reset();
        #3;
        got = dut_vec();
        cmp_cnt++;
        if (got !== 20'h0) begin
            err_cnt++;
            $display("FAIL reset_initial got=%h want=%h", got, 20'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        got = dut_vec();
        cmp_cnt++;
        if (got !== 20'h0) begin
            err_cnt++;
            $display("FAIL reset_clocked got=%h want=%h", got, 20'h0);
        end
        reset = 1'b1;
        $display("reset: outputs held low, released");
    endtask

    task automatic test_lw();
        logic [19:0] got, want;
        int exp_st[5] = '{0, 1, 2, 3, 4};
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, OP_LW, got, want);
            cmp_cnt++;
            if (got !== want) begin
                err_cnt++;
                $display("FAIL lw_model c%0d got=%h want=%h", i, got, want);
            end
            cmp_cnt++;
            if (got[19:16] !== 4'(exp_st[i]) || got[10] !== (i == 4) || got[8] !== (i == 4)
                || got[13] !== (i == 0)) begin
                err_cnt++;
                $display("FAIL lw_seq c%0d state=%0d rw=%b m2r=%b ir=%b want state=%0d",
                         i, got[19:16], got[10], got[8], got[13], exp_st[i]);
            end
        end
        $display("lw: 5-cycle sequence done");
    endtask

    task automatic test_sw_wait();
        logic [19:0] got, want;
        logic mr_seq[7] = '{1, 0, 0, 0, 0, 0, 1};
        int exp_st[7] = '{0, 1, 2, 5, 5, 5, 5};
        int mw_cnt = 0, rw_cnt = 0, mw_at = -1;
        for (int i = 0; i < 7; i++) begin
            tick(mr_seq[i], 1'b0, OP_SW, got, want);
            cmp_cnt++;
            if (got !== want || got[19:16] !== 4'(exp_st[i])) begin
                err_cnt++;
                $display("FAIL sw_wait c%0d got=%h want=%h state_req=%0d", i, got, want, exp_st[i]);
            end
            if (got[11] === 1'b1) begin mw_cnt++; mw_at = i; end
            if (got[10] === 1'b1) rw_cnt++;
        end
        cmp_cnt++;
        if (mw_cnt != 1 || mw_at != 6 || rw_cnt != 0) begin
            err_cnt++;
            $display("FAIL sw_strobes memwrite_cnt=%0d at=%0d regwrite_cnt=%0d want 1 at 6, 0",
                     mw_cnt, mw_at, rw_cnt);
        end
        $display("sw: MEMWR held 4 cycles, single write strobe");
    endtask

    task automatic test_beq();
        logic [19:0] got, want;
        for (int k = 0; k < 2; k++) begin
            logic z;
            z = (k == 0);
            for (int i = 0; i < 3; i++) begin
                tick(1'b1, z, OP_BEQ, got, want);
                cmp_cnt++;
                if (got !== want) begin
                    err_cnt++;
                    $display("FAIL beq_model z=%b c%0d got=%h want=%h", z, i, got, want);
                end
                if (i == 2) begin
                    cmp_cnt++;
                    if (got[19:16] !== 4'd8 || got[14] !== z || got[4:3] !== 2'b01) begin
                        err_cnt++;
                        $display("FAIL beq_ex z=%b state=%0d pcen=%b pcsrc=%b want 8,%b,01",
                                 z, got[19:16], got[14], got[4:3], z);
                    end
                end
            end
            $display("beq: zero=%b branch step checked", z);
        end
    endtask

    task automatic test_rtype_j();
        logic [19:0] got, want;
        int exp_st[7] = '{0, 1, 6, 7, 0, 1, 11};
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, 1'b0, (i < 4) ? OP_RTYPE : OP_J, got, want);
            cmp_cnt++;
            if (got !== want || got[19:16] !== 4'(exp_st[i])) begin
                err_cnt++;
                $display("FAIL rtype_j c%0d got=%h want=%h state_req=%0d", i, got, want, exp_st[i]);
            end
            if (i == 2 || i == 6) begin
                cmp_cnt++;
                if ((i == 2 && got[2:1] !== 2'b10) || (i == 6 && (got[4:3] !== 2'b10 || got[14] !== 1'b1))) begin
                    err_cnt++;
                    $display("FAIL rtype_j_ctl c%0d aluop=%b pcsrc=%b pcen=%b", i, got[2:1], got[4:3], got[14]);
                end
            end
        end
        $display("rtype+j: sequence 0,1,6,7,0,1,11 done");
    endtask

    task automatic test_illegal();
        logic [19:0] got, want;
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1, OP_BAD, got, want);
            cmp_cnt++;
            if (got !== want || got[19:16] !== 4'(i)) begin
                err_cnt++;
                $display("FAIL illegal c%0d got=%h want=%h", i, got, want);
            end
            cmp_cnt++;
            if (got[10] !== 1'b0 || got[11] !== 1'b0 || (i == 1 && got[14] !== 1'b0)) begin
                err_cnt++;
                $display("FAIL illegal_en c%0d rw=%b mw=%b pcen=%b want 0", i, got[10], got[11], got[14]);
            end
        end
        $display("illegal op: no-op, back to fetch");
    endtask

    task automatic test_timeout();
        logic [19:0] got, want;
        int pulses = 0, pulse_at = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, OP_BAD, got, want);
            cmp_cnt++;
            if (got !== want) begin
                err_cnt++;
                $display("FAIL timeout_model c%0d got=%h want=%h", i, got, want);
            end
            if (got[0] === 1'b1) begin pulses++; pulse_at = i; end
        end
        cmp_cnt++;
        if (pulses != 1 || pulse_at != MAXW) begin
            err_cnt++;
            $display("FAIL timeout_pulse count=%0d at=%0d want 1 at %0d", pulses, pulse_at, MAXW);
        end
        #2;
        reset = 1'b0;
        #1;
        got = dut_vec();
        cmp_cnt++;
        if (got !== 20'h0) begin
            err_cnt++;
            $display("FAIL reset_mid_wait got=%h want=%h", got, 20'h0);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        $display("timeout: single pulse after %0d waits, async reset cleared outputs", MAXW);
    endtask

    task automatic test_reset_memwr();
        logic [19:0] got, want;
        logic mr_seq[4] = '{1, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            tick(mr_seq[i], 1'b0, OP_SW, got, want);
            cmp_cnt++;
            if (got !== want) begin
                err_cnt++;
                $display("FAIL rst_memwr_pre c%0d got=%h want=%h", i, got, want);
            end
        end
        mem_ready = 1'b1;
        #1;
        got = dut_vec();
        cmp_cnt++;
        if (got[19:16] !== 4'd5 || got[11] !== 1'b1) begin
            err_cnt++;
            $display("FAIL rst_memwr_arm state=%0d mw=%b want 5,1", got[19:16], got[11]);
        end
        reset = 1'b0;
        #1;
        got = dut_vec();
        cmp_cnt++;
        if (got !== 20'h0) begin
            err_cnt++;
            $display("FAIL rst_memwr got=%h want=%h", got, 20'h0);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(1'b0, 1'b0, OP_BAD, got, want);
        cmp_cnt++;
        if (got !== want || got[19:16] !== 4'd0) begin
            err_cnt++;
            $display("FAIL rst_memwr_after got=%h want=%h", got, want);
        end
        $display("reset in MEMWR: write suppressed, back to fetch");
    endtask

    task automatic test_random();
        logic [19:0] got, want;
        logic [5:0] ops[7] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, OP_BAD};
        logic [5:0] cur_op;
        int txn = 0, prev_st;
        logic mr;
        cur_op = OP_LW;
        for (int i = 0; i < 600; i++) begin
            if (m_state == 0) cur_op = ops[$urandom_range(0, 6)];
            mr = ($urandom_range(0, 3) != 0);
            if (i >= 300 && i < 330) mr = 1'b0;
            prev_st = m_state;
            tick(mr, 1'($urandom_range(0, 1)), cur_op, got, want);
            cmp_cnt++;
            if (got !== want) begin
                err_cnt++;
                $display("FAIL random c%0d op=%b got=%h want=%h", i, cur_op, got, want);
            end
            if (prev_st != 0 && m_state == 0) begin
                txn++;
                $display("random txn %0d op=%b done at cycle %0d", txn, cur_op, i);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_rtype_j();
        test_illegal();
        test_timeout();
        test_reset_memwr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
